// File: rtl/frogger_pkg.sv
// Shared types and constants for the frogger obstacle lanes: lane FSM state
// encoding plus the seed, taps and step function of the 16-bit spawn LFSR.
package frogger_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HIT
  } lane_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Right-shifting Fibonacci step; TAPS bit k (1-based tap k+1) samples state bit 15-k.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic fb;
    fb = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (LFSR_TAPS[4'(i)]) fb = fb ^ s[4'(15 - i)];
    end
    return {fb, s[15:1]};
  endfunction

endpackage

// File: rtl/lane_shifter_if.sv
// Control/status bundle between the level logic and one obstacle lane.
interface lane_shifter_if #(
  parameter int WIDTH = 16
);
  logic                     enable;
  logic                     start;
  logic                     clear;
  logic                     load;
  logic [WIDTH-1:0]         pattern;
  logic                     frog_here;
  logic [$clog2(WIDTH)-1:0] frog_col;
  logic [WIDTH-1:0]         row;
  logic                     collision;
  logic [7:0]               shift_count;

  modport master (
    output enable, start, clear, load, pattern, frog_here, frog_col,
    input  row, collision, shift_count
  );

  modport slave (
    input  enable, start, clear, load, pattern, frog_here, frog_col,
    output row, collision, shift_count
  );
endinterface

// File: rtl/lane_lfsr.sv
// 16-bit Fibonacci LFSR supplying fresh obstacle bits; steps only when advance is high.
module lane_lfsr
  import frogger_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic advance,
  output logic bit_out
);

  logic [15:0] state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        state_q <= LFSR_SEED;
    else if (advance) state_q <= lfsr_next(state_q);
  end

  assign bit_out = state_q[0];

endmodule

// File: rtl/lane_shifter.sv
// One scrolling obstacle lane with IDLE/RUN/HIT control and frog collision detect.
// Optional macro SPAWN_LFSR_EN refills the vacated bit from lane_lfsr instead of rotating.
module lane_shifter
  import frogger_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIR   = 0
) (
  input  logic          clk,
  input  logic          reset,
  lane_shifter_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  lane_state_t      state_q, state_d;
  logic [WIDTH-1:0] row_q, shifted;
  logic [7:0]       count_q;
  logic             in_range, detect, do_load, do_shift, fill;

  // Zero-extended compare so a non-power-of-two WIDTH rejects columns past the lane.
  assign in_range = {1'b0, bus.frog_col} < (CW + 1)'(WIDTH);
  assign detect   = (state_q == RUN) && bus.frog_here && in_range && row_q[bus.frog_col];
  assign do_load  = bus.load && (state_q != HIT);
  assign do_shift = (state_q == RUN) && bus.enable && !detect && !bus.load;

`ifdef SPAWN_LFSR_EN
  lane_lfsr u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (do_shift),
    .bit_out (fill)
  );
`else
  assign fill = (DIR == 0) ? row_q[0] : row_q[WIDTH-1];
`endif

  generate
    if (DIR == 0) begin : g_down
      assign shifted = {fill, row_q[WIDTH-1:1]};
    end else begin : g_up
      assign shifted = {row_q[WIDTH-2:0], fill};
    end
  endgenerate

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (do_load)       row_q <= bus.pattern;
      else if (do_shift) row_q <= shifted;
      if (do_shift)      count_q <= count_q + 8'd1;
    end
  end

  // NOTE: state_d is defaulted first so no path through this block can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (detect)    state_d = HIT;
      HIT:     if (bus.clear) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.row         = row_q;
  assign bus.collision   = (state_q == HIT);
  assign bus.shift_count = count_q;

endmodule

// File: tb/tb_lane_shifter.sv
// Randomised bench for lane_shifter (WIDTH=16, DIR=0) against a cycle-level model;
// define SPAWN_LFSR_EN for both bench and RTL to cover the LFSR refill build.
module tb_lane_shifter;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt;

  lane_shifter_if #(.WIDTH(W)) bus ();

  lane_shifter #(.WIDTH(W), .DIR(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // mode: 0 idle, 1 running, 2 hit
  typedef struct {
    int          mode;
    logic [W-1:0] row;
    int          cnt;
    logic [15:0] lfsr;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.mode = 0;
    r.row  = '0;
    r.cnt  = 0;
    r.lfsr = 16'hACE1;
    return r;
  endfunction

  function automatic model_t model_step(input model_t s, input logic en, st, cl, ld,
                                        input logic [W-1:0] pat, input logic fh,
                                        input logic [3:0] fc);
    model_t n;
    bit     hit, shift;
    logic   fill;
    n     = s;
    hit   = (s.mode == 1) && fh && (int'(fc) < W) && s.row[fc];
    shift = (s.mode == 1) && en && !hit && !ld;
`ifdef SPAWN_LFSR_EN
    fill = s.lfsr[0];
`else
    fill = s.row[0];
`endif
    if (ld && s.mode != 2) n.row = pat;
    else if (shift)        n.row = (s.row >> 1) | (W'(fill) << (W - 1));
    if (shift) begin
      n.cnt  = (s.cnt + 1) % 256;
      n.lfsr = {s.lfsr[0] ^ s.lfsr[2] ^ s.lfsr[3] ^ s.lfsr[5], s.lfsr[15:1]};
    end
    if (s.mode == 0 && st)       n.mode = 1;
    else if (s.mode == 1 && hit) n.mode = 2;
    else if (s.mode == 2 && cl)  n.mode = 0;
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= model_reset();
    else m <= model_step(m, bus.enable, bus.start, bus.clear, bus.load,
                         bus.pattern, bus.frog_here, bus.frog_col);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cyc_row", 32'(bus.row), 32'(m.row));
    check("cyc_collision", 32'(bus.collision), 32'(m.mode == 2));
    check("cyc_count", 32'(bus.shift_count), 32'(m.cnt));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    bus.enable    = 1'b0;
    bus.start     = 1'b0;
    bus.clear     = 1'b0;
    bus.load      = 1'b0;
    bus.pattern   = '0;
    bus.frog_here = 1'b0;
    bus.frog_col  = '0;
    repeat (2) cyc();
    reset = 1'b0;
    cyc();
    check("reset_row", 32'(bus.row), 32'h0);
    check("reset_collision", 32'(bus.collision), 32'h0);
    check("reset_count", 32'(bus.shift_count), 32'h0);

`ifdef SPAWN_LFSR_EN
    bus.load = 1'b1; bus.pattern = 16'h0000; cyc();
    bus.load = 1'b0; bus.start = 1'b1; cyc();
    bus.start = 1'b0; bus.enable = 1'b1; cyc();
    bus.enable = 1'b0;
    check("spawn_row15", 32'(bus.row[15]), 32'h1);
    check("spawn_count", 32'(bus.shift_count), 32'd1);
    check("spawn_model_row", 32'(m.row), 32'h8000);
    exp_cnt = 1;
`else
    bus.load = 1'b1; bus.pattern = 16'h0001; cyc();
    bus.load = 1'b0; bus.start = 1'b1; cyc();
    bus.start = 1'b0; bus.enable = 1'b1;
    repeat (3) cyc();
    bus.enable = 1'b0;
    check("rotate_row", 32'(bus.row), 32'h2000);
    check("rotate_count", 32'(bus.shift_count), 32'd3);
    check("rotate_model_row", 32'(m.row), 32'h2000);
    exp_cnt = 3;
`endif

    // load coincident with a shift tick
    bus.load = 1'b1; bus.pattern = 16'h00FF; bus.enable = 1'b1; cyc();
    bus.load = 1'b0; bus.enable = 1'b0;
    check("priority_row", 32'(bus.row), 32'h00FF);
    check("priority_count", 32'(bus.shift_count), 32'(exp_cnt));

    // 256 shifts: counter wraps back to its starting value
    bus.enable = 1'b1;
    repeat (256) cyc();
    bus.enable = 1'b0;
    check("wrap_count", 32'(bus.shift_count), 32'(exp_cnt));
`ifndef SPAWN_LFSR_EN
    check("wrap_row", 32'(bus.row), 32'h00FF);
`endif

    bus.load = 1'b1; bus.pattern = 16'h0010; bus.frog_col = 4'd4; cyc();
    bus.load = 1'b0;
    check("pre_hit_collision", 32'(bus.collision), 32'h0);
    bus.frog_here = 1'b1; cyc();
    check("hit_collision", 32'(bus.collision), 32'h1);
    bus.enable = 1'b1; cyc();
    bus.enable = 1'b0;
    check("hit_row_hold", 32'(bus.row), 32'h0010);
    check("hit_count_hold", 32'(bus.shift_count), 32'(exp_cnt));
    bus.load = 1'b1; bus.pattern = 16'h0F0F; cyc();
    bus.load = 1'b0;
    check("hit_load_ignored", 32'(bus.row), 32'h0010);
    bus.start = 1'b1; cyc();
    bus.start = 1'b0;
    check("hit_start_ignored", 32'(bus.collision), 32'h1);
    bus.clear = 1'b1; cyc();
    bus.clear = 1'b0;
    check("clear_collision", 32'(bus.collision), 32'h0);
    bus.enable = 1'b1; cyc();
    bus.enable = 1'b0;
    check("idle_row_hold", 32'(bus.row), 32'h0010);
    check("idle_count_hold", 32'(bus.shift_count), 32'(exp_cnt));

    for (int i = 0; i < 2000; i++) begin
      bus.enable    = 1'($urandom_range(0, 1));
      bus.start     = ($urandom_range(0, 15) == 0);
      bus.clear     = ($urandom_range(0, 15) == 0);
      bus.load      = ($urandom_range(0, 31) == 0);
      bus.pattern   = W'($urandom);
      bus.frog_here = ($urandom_range(0, 3) == 0);
      bus.frog_col  = 4'($urandom);
      cyc();
    end

    // reset mid-RUN, asserted between edges
    bus.enable = 1'b0; bus.start = 1'b0; bus.load = 1'b0; bus.frog_here = 1'b0;
    bus.clear = 1'b1; cyc();
    bus.clear = 1'b0; bus.load = 1'b1; bus.pattern = 16'h00F0; cyc();
    bus.load = 1'b0; bus.start = 1'b1; cyc();
    bus.start = 1'b0; bus.enable = 1'b1; cyc();
    #3 reset = 1'b1;
    #1;
    check("async_reset_row", 32'(bus.row), 32'h0);
    check("async_reset_collision", 32'(bus.collision), 32'h0);
    check("async_reset_count", 32'(bus.shift_count), 32'h0);
    cyc();
    reset = 1'b0;
    repeat (3) cyc();
    bus.enable = 1'b0;
    check("post_reset_row", 32'(bus.row), 32'h0);
    check("post_reset_count", 32'(bus.shift_count), 32'h0);

    // reset mid-HIT
    bus.load = 1'b1; bus.pattern = 16'h0001; cyc();
    bus.load = 1'b0; bus.start = 1'b1; cyc();
    bus.start = 1'b0; bus.frog_here = 1'b1; bus.frog_col = 4'd0; cyc();
    check("hit2_collision", 32'(bus.collision), 32'h1);
    #3 reset = 1'b1;
    #1;
    check("hit_reset_collision", 32'(bus.collision), 32'h0);
    check("hit_reset_row", 32'(bus.row), 32'h0);
    cyc();
    reset = 1'b0; bus.frog_here = 1'b0;
    repeat (2) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lane_shifter.md
LANE_SHIFTER -- requirements
Module: lane_shifter

Interface
REQ-001 Parameter WIDTH, default 16, number of columns in one obstacle lane.
REQ-002 Parameter DIR, default 0, shift direction: 0 = toward bit 0, 1 = toward bit WIDTH-1.
REQ-003 clk  input  1  system clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  one-cycle speed tick from the level tick generator; one tick allows one shift.
REQ-006 start  input  1  one-cycle pulse; leaves IDLE.
REQ-007 clear  input  1  one-cycle pulse; leaves HIT.
REQ-008 load  input  1  one-cycle pulse; loads pattern into row.
REQ-009 pattern  input  WIDTH  obstacle pattern to load.
REQ-010 frog_here  input  1  high while the frog occupies this lane.
REQ-011 frog_col  input  $clog2(WIDTH)  frog column index.
REQ-012 row  output  WIDTH  current obstacle occupancy; 1 = obstacle.
REQ-013 collision  output  1  high while in HIT.
REQ-014 shift_count  output  8  number of shifts performed since reset.

Function
REQ-015 FSM states SHALL be IDLE, RUN and HIT.
REQ-016 IDLE -> RUN on start; RUN -> HIT on collision detect; HIT -> IDLE on clear; all other inputs leave the state unchanged.
REQ-017 Collision detect: state == RUN and frog_here == 1 and row[frog_col] == 1, evaluated on the registered row each cycle.
REQ-018 In RUN with enable = 1 and no collision detect, row SHALL shift one position per DIR, and shift_count SHALL increment by 1.
REQ-019 The vacated bit SHALL take the bit shifted out, so the pattern rotates with no loss.
REQ-020 shift_count SHALL wrap from 255 to 0.
REQ-021 Collision detect and enable in the same cycle: enter HIT, no shift, no count.
REQ-022 load in IDLE or RUN: row <= pattern next cycle; load wins over a same-cycle shift, and no count is taken.
REQ-023 load in HIT SHALL be ignored.
REQ-024 In IDLE and HIT, row and shift_count SHALL hold.
REQ-025 collision SHALL be high exactly while state == HIT, asserting 1 cycle after detect and deasserting 1 cycle after clear.
REQ-026 start outside IDLE and clear outside HIT SHALL be ignored.
REQ-027 frog_col >= WIDTH SHALL never detect a collision.

Reset
REQ-028 reset SHALL asynchronously force: state = IDLE, row = 0, collision = 0, shift_count = 0, LFSR = 16'hACE1.
REQ-029 reset asserted mid-RUN or mid-HIT SHALL discard the pattern; after release, outputs stay at reset values until load or start.

Configuration
REQ-030 Macro SPAWN_LFSR_EN:
- Defined: the vacated bit is filled from LFSR bit 0.
- The LFSR is 16-bit Fibonacci, taps 16,14,13,11, and advances only on cycles where a shift occurs.
- Undefined: pure rotation per REQ-019; no LFSR flops are present.

Structure
REQ-031 Shared package frogger_pkg SHALL hold:
- lane_state_t enum (IDLE, RUN, HIT)
- LFSR_SEED = 16'hACE1
- LFSR_TAPS = 16'hB400
REQ-032 The LFSR SHALL be a sub-module lane_lfsr (ports: clk, reset, advance, bit_out), instantiated only under SPAWN_LFSR_EN.

Verification
REQ-033 Rotation: WIDTH=16, DIR=0.
- Stimulus: load 16'h0001, start, 3 enable ticks.
- Required: row = 16'h2000 and shift_count = 3 (the bit at position 0 rotates to position 15, then 14, then 13).
REQ-034 Collision: row = 16'h0010, frog_here = 1, frog_col = 4 in RUN.
- Required: collision = 1 next cycle.
- A subsequent enable leaves row = 16'h0010.
- clear returns to IDLE with collision = 0.
REQ-035 Priority: load 16'h00FF coincident with enable in RUN.
- Required: row = 16'h00FF and shift_count unchanged.
REQ-036 Wrap: 256 enable ticks in RUN with no collision.
- Required: shift_count = 0 and row equals the loaded pattern (WIDTH divides 256).
REQ-037 Reset: assert reset mid-RUN between clock edges.
- Required: row = 0, collision = 0 and state = IDLE immediately, without waiting for a clock edge.
REQ-038 SPAWN_LFSR_EN defined: load 16'h0000, start, 1 enable.
- Required: row[15] = 1 (bit 0 of 16'hACE1 is 1); shift_count = 1.
